// File: rtl/cell_renderer.sv
// rtl/cell_renderer.sv - double-buffered NxN cell grid to RGB pixel renderer
`timescale 1ns/1ps
module cell_renderer #(
    parameter int         GRID_X0   = 253,
    parameter int         GRID_Y0   = 64,
    parameter int         CELL      = 30,
    parameter int         N         = 14,
    parameter logic [7:0] LIVE_RGB  = 8'h1C,
    parameter logic [7:0] DEAD_RGB  = 8'h00,
    parameter logic [7:0] FRAME_RGB = 8'h92
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_en,
    input  logic [9:0]   hc,
    input  logic [9:0]   vc,
    input  logic         bright,
    input  logic         row_valid,
    input  logic [3:0]   row_idx,
    input  logic [N-1:0] row_data,
    output logic         row_ready,
    output logic         swap_done,
    output logic [7:0]   rgb
);

    // Counter widths: sub-cell position within a cell, and cell index within the grid.
    localparam int SW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    // Grid bounds and legal counter ranges, held as 32-bit unsigned for compares.
    localparam logic [31:0] X_LO   = GRID_X0;
    localparam logic [31:0] X_HI   = GRID_X0 + N * CELL;
    localparam logic [31:0] Y_LO   = GRID_Y0;
    localparam logic [31:0] Y_HI   = GRID_Y0 + N * CELL;
    localparam logic [31:0] HC_MAX = 800;
    localparam logic [31:0] VC_MAX = 525;
    localparam logic [31:0] N32    = N;
    localparam logic [9:0]  X0_10  = 10'(GRID_X0);
    localparam logic [9:0]  Y0_10  = 10'(GRID_Y0);

    // Board buffers: front is what is being drawn, back is what upstream is filling.
    logic [N-1:0][N-1:0] front;
    logic [N-1:0][N-1:0] back;
    logic                pending;

    // Position tracking state: values belonging to the last pixel seen.
    logic [SW-1:0] col_sub;
    logic [IW-1:0] col_cell;
    logic [SW-1:0] row_sub;
    logic [IW-1:0] row_cell;
    logic [9:0]    last_hc;
    logic [9:0]    last_vc;

    // Position of the current pixel, derived from the stored state.
    logic [SW-1:0] col_sub_cur;
    logic [IW-1:0] col_cell_cur;
    logic [SW-1:0] row_sub_cur;
    logic [IW-1:0] row_cell_cur;

    logic [31:0] hc32;
    logic [31:0] vc32;
    logic [31:0] row_idx32;
    logic        in_grid;
    logic        cell_live;
    logic        swap_go;
    logic        row_fire;
    logic [7:0]  rgb_next;

    assign hc32      = 32'(hc);
    assign vc32      = 32'(vc);
    assign row_idx32 = 32'(row_idx);

    assign row_ready = ~pending;
    assign row_fire  = row_valid & row_ready;
    assign swap_go   = pix_en & (hc == 10'd0) & (vc == 10'd0) & pending;

    // Column position: reload at the grid's left edge, step once per new hc, stop at the last cell.
    always_comb begin
        col_sub_cur  = col_sub;
        col_cell_cur = col_cell;
        if (hc == X0_10) begin
            col_sub_cur  = '0;
            col_cell_cur = '0;
        end else if (hc != last_hc) begin
            if (col_sub == SUB_LAST) begin
                if (col_cell != IDX_LAST) begin
                    col_sub_cur  = '0;
                    col_cell_cur = col_cell + 1'b1;
                end
            end else begin
                col_sub_cur = col_sub + 1'b1;
            end
        end
    end

    // Row position: reload on the grid's top line, step once per new line, stop at the last cell.
    always_comb begin
        row_sub_cur  = row_sub;
        row_cell_cur = row_cell;
        if (vc == Y0_10) begin
            row_sub_cur  = '0;
            row_cell_cur = '0;
        end else if (vc != last_vc) begin
            if (row_sub == SUB_LAST) begin
                if (row_cell != IDX_LAST) begin
                    row_sub_cur  = '0;
                    row_cell_cur = row_cell + 1'b1;
                end
            end else begin
                row_sub_cur = row_sub + 1'b1;
            end
        end
    end

    // Grid membership uses the raw counts, so out-of-range hc/vc never land in a cell.
    always_comb begin
        in_grid = (hc32 >= X_LO) && (hc32 < X_HI) && (hc32 < HC_MAX) &&
                  (vc32 >= Y_LO) && (vc32 < Y_HI) && (vc32 < VC_MAX);
    end

    // Cell lookup and colour priority; reads front before any same-cycle swap lands.
    always_comb begin
        cell_live = front[row_cell_cur][col_cell_cur];
        if (!bright) begin
            rgb_next = 8'h00;
        end else if (in_grid) begin
            rgb_next = cell_live ? LIVE_RGB : DEAD_RGB;
        end else begin
            rgb_next = FRAME_RGB;
        end
    end

    // Row loading into back, end-of-board flag, and the frame-start buffer swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front     <= '0;
            back      <= '0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= swap_go;
            if (swap_go) begin
                front   <= back;
                pending <= 1'b0;
            end else if (row_fire) begin
                if (row_idx32 < N32) begin
                    back[row_idx[IW-1:0]] <= row_data;
                end
                if (row_idx32 == N32 - 32'd1) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // Position counters advance only on pixel strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_sub  <= '0;
            col_cell <= '0;
            row_sub  <= '0;
            row_cell <= '0;
            last_hc  <= '0;
            last_vc  <= '0;
        end else if (pix_en) begin
            col_sub  <= col_sub_cur;
            col_cell <= col_cell_cur;
            row_sub  <= row_sub_cur;
            row_cell <= row_cell_cur;
            last_hc  <= hc;
            last_vc  <= vc;
        end
    end

    // Output colour register, held between pixel strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= 8'h00;
        end else if (pix_en) begin
            rgb <= rgb_next;
        end
    end

endmodule

// File: tb/tb_cell_renderer.sv
// tb/tb_cell_renderer.sv - self-checking bench for cell_renderer
`timescale 1ns/1ps
module tb_cell_renderer;

    localparam int X0 = 253;
    localparam int Y0 = 64;
    localparam int C  = 30;
    localparam int NN = 14;

    logic          clk;
    logic          rst;
    logic          pix_en;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          bright;
    logic          row_valid;
    logic [3:0]    row_idx;
    logic [NN-1:0] row_data;
    logic          row_ready;
    logic          swap_done;
    logic [7:0]    rgb;

    cell_renderer #(
        .GRID_X0(X0), .GRID_Y0(Y0), .CELL(C), .N(NN),
        .LIVE_RGB(8'h1C), .DEAD_RGB(8'h00), .FRAME_RGB(8'h92)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hc(hc), .vc(vc), .bright(bright),
        .row_valid(row_valid), .row_idx(row_idx), .row_data(row_data),
        .row_ready(row_ready), .swap_done(swap_done), .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [NN-1:0] mfront [NN];
    logic [NN-1:0] mback  [NN];
    bit            mpending;
    logic [7:0]    exp_q [$];
    logic [7:0]    sb_exp;
    logic          sampled;

    typedef struct {
        int         phase;
        string      nm;
        int         h;
        int         v;
        bit         b;
        logic [7:0] e;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] model_rgb(input int h, input int v, input bit b);
        if (!b) return 8'h00;
        if (h >= X0 && h < X0 + NN * C && v >= Y0 && v < Y0 + NN * C && h < 800 && v < 525)
            return mfront[(v - Y0) / C][(h - X0) / C] ? 8'h1C : 8'h00;
        return 8'h92;
    endfunction

    function automatic void add(input int p, input string nm, input int h, input int v,
                                input bit b, input logic [7:0] e);
        vec_t t;
        t.phase = p; t.nm = nm; t.h = h; t.v = v; t.b = b; t.e = e;
        tbl.push_back(t);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NN; i++) begin
            mfront[i] = '0;
            mback[i]  = '0;
        end
        mpending = 0;
    endfunction

    // Scoreboard: every strobed pixel is compared one clock later.
    always @(posedge clk) sampled <= pix_en;

    always @(negedge clk) begin
        if (sampled) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: rgb %0h with nothing expected", rgb);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("pixel_rgb", 32'(rgb), 32'(sb_exp));
            end
        end
    end

    task automatic pixel(input int h, input int v, input bit b);
        @(negedge clk);
        pix_en = 1'b1;
        hc     = 10'(h);
        vc     = 10'(v);
        bright = b;
        exp_q.push_back(model_rgb(h, v, b));
    endtask

    task automatic load_row(input int idx, input logic [NN-1:0] d);
        @(negedge clk);
        row_valid = 1'b1;
        row_idx   = 4'(idx);
        row_data  = d;
        chk("row_ready_before_load", 32'(row_ready), 32'(!mpending));
        if (!mpending) begin
            if (idx < NN) mback[idx] = d;
            if (idx == NN - 1) mpending = 1;
        end
        @(negedge clk);
        row_valid = 1'b0;
        chk("row_ready_after_load", 32'(row_ready), 32'(!mpending));
    endtask

    task automatic frame_start();
        bit exp_pulse;
        exp_pulse = mpending;
        pixel(0, 0, 0);
        if (mpending) begin
            for (int i = 0; i < NN; i++) mfront[i] = mback[i];
            mpending = 0;
        end
        @(negedge clk);
        pix_en = 1'b0;
        chk("swap_done_pulse", 32'(swap_done), 32'(exp_pulse));
        chk("row_ready_after_frame", 32'(row_ready), 32'(!mpending));
        @(negedge clk);
        chk("swap_done_single", 32'(swap_done), 32'd0);
    endtask

    // Walk the raster so the counters reach (h, v) the way a real scan would.
    task automatic check_px(input string nm, input int h, input int v, input bit b,
                            input logic [7:0] e);
        if (v >= Y0)
            for (int l = Y0; l < v; l++) pixel(0, l, 1);
        if (h >= X0 - 3)
            for (int x = X0 - 3; x < h; x++) pixel(x, v, 1);
        pixel(h, v, b);
        @(negedge clk);
        pix_en = 1'b0;
        chk(nm, 32'(rgb), 32'(e));
        @(negedge clk);
        chk({nm, "_hold"}, 32'(rgb), 32'(e));
    endtask

    task automatic run_phase(input int p);
        foreach (tbl[i])
            if (tbl[i].phase == p)
                check_px(tbl[i].nm, tbl[i].h, tbl[i].v, tbl[i].b, tbl[i].e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        add(1, "x0y0_live",     253,  64, 1, 8'h1C);
        add(1, "x1_dead",       283,  64, 1, 8'h00);
        add(1, "cell00_last",   282,  93, 1, 8'h1C);
        add(1, "row1_first",    253,  94, 1, 8'h1C);
        add(1, "left_of_grid",  252, 100, 1, 8'h92);
        add(1, "cell13_13",     672, 483, 1, 8'h00);
        add(1, "right_of_grid", 673, 483, 1, 8'h92);
        add(1, "below_grid",    253, 484, 1, 8'h92);
        add(1, "dark",          300, 300, 0, 8'h00);
        add(1, "hc_out_range",  900, 100, 1, 8'h92);
        add(1, "vc_out_range",  300, 600, 1, 8'h92);
        add(1, "no_extra_row",  410,  64, 1, 8'h00);
        add(2, "diag13_13",     672, 483, 1, 8'h1C);
        add(2, "r13c12",        642, 483, 1, 8'h00);
        add(2, "r13c0",         253, 483, 1, 8'h1C);
        add(2, "r5c4",          402, 214, 1, 8'h00);
        add(2, "r5c5",          410, 214, 1, 8'h1C);
        add(3, "rst_r0c0",      253,  64, 1, 8'h00);
        add(3, "rst_r6c6",      440, 244, 1, 8'h00);
        add(3, "rst_r12c13",    672, 453, 1, 8'h00);
        add(3, "rst_r13c0",     253, 483, 1, 8'h1C);

        rst = 1'b1; pix_en = 1'b0; hc = '0; vc = '0; bright = 1'b0;
        row_valid = 1'b0; row_idx = '0; row_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_row_ready", 32'(row_ready), 32'd1);
        chk("reset_swap_done", 32'(swap_done), 32'd0);
        chk("reset_rgb",       32'(rgb),       32'd0);
        rst = 1'b0;

        // Phase 1: column 0 live in every row, with a row offered while pending.
        for (int r = 0; r < NN; r++) load_row(r, 14'h0001);
        @(negedge clk);
        row_valid = 1'b1; row_idx = 4'd0; row_data = 14'h3FFF;
        for (int i = 0; i < 4; i++) begin
            chk("row_ready_held_pending", 32'(row_ready), 32'd0);
            @(negedge clk);
        end
        row_valid = 1'b0;
        frame_start();
        run_phase(1);

        // Phase 2: out-of-range row index, diagonal board, two frame starts.
        load_row(15, 14'h3FFF);
        for (int r = 0; r < NN - 1; r++) load_row(r, 14'(1 << r));
        load_row(NN - 1, 14'h2001);
        frame_start();
        frame_start();
        run_phase(2);

        // Phase 3: reset in the middle of a load, then only the last row.
        for (int r = 0; r < 7; r++) load_row(r, 14'h3FFF);
        @(posedge clk);
        #2 rst = 1'b1;
        model_clear();
        #1;
        chk("async_rst_rgb",       32'(rgb),       32'd0);
        chk("async_rst_row_ready", 32'(row_ready), 32'd1);
        chk("async_rst_swap_done", 32'(swap_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        row_valid = 1'b1; row_idx = 4'(NN - 1); row_data = 14'h0001;
        chk("first_edge_ready", 32'(row_ready), 32'd1);
        mback[NN - 1] = 14'h0001;
        mpending = 1;
        @(negedge clk);
        row_valid = 1'b0;
        chk("first_edge_accepted", 32'(row_ready), 32'd0);
        frame_start();
        run_phase(3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
